// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular instruction fetch queue with PC tags and head
// field split. Optional same-cycle bypass when IQ_BYPASS_EN is defined.
//
// Ports:
//   clk, rst_              clock; async active-low reset
//   in_valid/in_ready      fetch side handshake, in_data + in_pc payload
//   out_valid/out_ready    decode side handshake
//   instr, instr_pc        head word and PC (NOP / 0 when out_valid=0)
//   opcode..imm            head fields split out of instr
//   r_type/i_type/j_type   instruction class from opcode
//   flush                  drop every held entry (taken branch / jump)
//   count, full, empty     occupancy from the registered count
module instr_fetch_queue #(
  parameter int BITS = 32,
  parameter int PC_BITS = 32,
  parameter int DEPTH = 4,
  parameter int REG_WORDS = 32,
  parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter logic [BITS-1:0] NOP = 32'h0000_0020
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   in_valid,
  input  logic [BITS-1:0]        in_data,
  input  logic [PC_BITS-1:0]     in_pc,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        instr,
  output logic [PC_BITS-1:0]     instr_pc,
  output logic [5:0]             opcode,
  output logic [5:0]             funct,
  output logic [ADDR_LEFT:0]     rs,
  output logic [ADDR_LEFT:0]     rt,
  output logic [ADDR_LEFT:0]     rd,
  output logic [4:0]             shamt,
  output logic [BITS/2-1:0]      imm,
  output logic                   r_type,
  output logic                   i_type,
  output logic                   j_type,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [BITS-1:0]    r_data [DEPTH];
  logic [PC_BITS-1:0] r_pc   [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_wr;
  logic               w_byp;
  logic [BITS-1:0]    w_word;
  logic [PC_BITS-1:0] w_wpc;

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !flush;

`ifdef IQ_BYPASS_EN
  // Empty queue with a ready consumer: hand the fetch word straight
  // through instead of parking it for a cycle.
  assign w_byp  = w_empty && in_valid && out_ready && !flush;
  assign w_word = w_byp ? in_data : r_data[r_rd_ptr];
  assign w_wpc  = w_byp ? in_pc : r_pc[r_rd_ptr];
`else
  assign w_byp  = 1'b0;
  assign w_word = r_data[r_rd_ptr];
  assign w_wpc  = r_pc[r_rd_ptr];
`endif

  assign out_valid = !w_empty || w_byp;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = !w_empty && out_ready && !flush;
  // A bypassed word is consumed on the fly and never stored.
  assign w_wr      = w_push && !w_byp;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wr_ptr] <= in_data;
      r_pc[r_wr_ptr]   <= in_pc;
    end
  end

  always_comb begin
    instr    = NOP;
    instr_pc = '0;
    opcode   = 6'h00;
    funct    = 6'h20;
    rs       = '0;
    rt       = '0;
    rd       = '0;
    shamt    = 5'd0;
    imm      = '0;
    r_type   = 1'b1;
    i_type   = 1'b0;
    j_type   = 1'b0;
    if (out_valid) begin
      instr    = w_word;
      instr_pc = w_wpc;
      opcode   = w_word[31:26];
      rs       = w_word[21 +: ADDR_LEFT+1];
      rt       = w_word[16 +: ADDR_LEFT+1];
      rd       = w_word[11 +: ADDR_LEFT+1];
      shamt    = w_word[10:6];
      imm      = w_word[BITS/2-1:0];
      r_type   = (opcode == 6'h00);
      j_type   = (opcode == 6'h02) ||
                 (opcode == 6'h03);
      i_type   = !r_type && !j_type;
      funct    = r_type ? w_word[5:0] : 6'h00;
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every
// cycle, plus directed literal checks for reset, fill, decode, flush, bypass.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        r_type;
  logic        i_type;
  logic        j_type;
  logic        flush;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_data(in_data),
    .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm),
    .r_type(r_type), .i_type(i_type),
    .j_type(j_type), .flush(flush),
    .count(count), .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  logic [63:0] q[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic bit model_byp();
    return BYP && q.size() == 0 && in_valid &&
           out_ready && !flush;
  endfunction

  // Advance the reference queue by one clock edge.
  function automatic void upd();
    bit pop, push;
    if (!rst_ || flush) begin
      q.delete();
      return;
    end
    pop  = q.size() > 0 && out_ready;
    push = in_valid && q.size() < DEPTH &&
           !model_byp();
    if (pop) void'(q.pop_front());
    if (push) q.push_back({in_data, in_pc});
  endfunction

  logic        e_v;
  logic [31:0] e_w;
  logic [31:0] e_p;
  logic        e_r;
  logic        e_j;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (model_byp()) begin
        e_v = 1'b1; e_w = in_data; e_p = in_pc;
      end else if (q.size() > 0) begin
        e_v = 1'b1; e_w = q[0][63:32]; e_p = q[0][31:0];
      end else begin
        e_v = 1'b0; e_w = 32'h20; e_p = 32'h0;
      end
      e_r = !e_v || e_w[31:26] == 6'h00;
      e_j = e_v && (e_w[31:26] == 6'h02 ||
                    e_w[31:26] == 6'h03);
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_empty", 64'(empty), 64'(q.size() == 0));
      chk("m_full", 64'(full), 64'(q.size() == DEPTH));
      chk("m_in_ready", 64'(in_ready),
          64'(q.size() < DEPTH && !flush));
      chk("m_out_valid", 64'(out_valid), 64'(e_v));
      chk("m_instr", 64'(instr), 64'(e_w));
      chk("m_instr_pc", 64'(instr_pc), 64'(e_p));
      chk("m_opcode", 64'(opcode), 64'(e_w[31:26]));
      chk("m_class", {61'd0, r_type, i_type, j_type},
          {61'd0, e_r, !e_r && !e_j, e_j});
      chk("m_funct", 64'(funct),
          64'(!e_v ? 6'h20 : (e_r ? e_w[5:0] : 6'h0)));
      chk("m_regs", {49'd0, rs, rt, rd},
          {49'd0, e_w[25:21], e_w[20:16], e_w[15:11]});
      chk("m_shamt", 64'(shamt), 64'(e_w[10:6]));
      if (e_v)
        chk("m_imm", 64'(imm), 64'(e_w[15:0]));
    end
  end

  task automatic drive(input logic v,
                       input logic [31:0] d,
                       input logic [31:0] p,
                       input logic r,
                       input logic f);
    in_valid = v; in_data = d; in_pc = p;
    out_ready = r; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask

  logic [31:0] seq[$];
  logic [31:0] d;

  initial begin
    rst_ = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_ = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h20);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_r_type", 64'(r_type), 64'd1);
    chk("rst_funct", 64'(funct), 64'h20);
    cmp_en = 1'b1;

    // Mid-stream asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hA000_0000 + i, 32'h100 + 4 * i, 0, 0);
      tick();
    end
    chk("pre_rst_count", 64'(count), 64'd3);
    drive(0, 0, 0, 0, 0);
    #2 rst_ = 1'b0;
    q.delete();
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_instr", 64'(instr), 64'h0000_0020);
    chk("arst_r_type", 64'(r_type), 64'd1);
    chk("arst_funct", 64'(funct), 64'h20);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1 rst_ = 1'b1;
    tick();

    // Fill to DEPTH, refuse a fifth, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hB000_0010 + i, 32'h200 + 4 * i, 0, 0);
      tick();
    end
    drive(1, 32'hB000_00FF, 32'h2FC, 0, 0);
    #1;
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fill_count5", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      #1;
      chk("drain_instr", 64'(instr), 64'(32'hB000_0010 + i));
      chk("drain_pc", 64'(instr_pc), 64'(32'h200 + 4 * i));
      tick();
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Steady push+pop at count=2 across two pointer wraps.
    for (int i = 0; i < 10; i++)
      seq.push_back(32'hC000_0000 + i);
    for (int i = 0; i < 2; i++) begin
      drive(1, seq[i], 32'h300 + 4 * i, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, seq[i+2], 32'h300 + 4 * (i + 2), 1, 0);
      #1;
      chk("sim_head", 64'(instr), 64'(seq[i]));
      tick();
      chk("sim_count", 64'(count), 64'd2);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0);
      #1;
      chk("sim_tail", 64'(instr), 64'(seq[i+8]));
      tick();
    end

    // Field split on an lw and a jump.
    drive(1, 32'h8C22_0004, 32'h400, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("dec_opcode", 64'(opcode), 64'h23);
    chk("dec_rs", 64'(rs), 64'd1);
    chk("dec_rt", 64'(rt), 64'd2);
    chk("dec_imm", 64'(imm), 64'h0004);
    chk("dec_i_type", 64'(i_type), 64'd1);
    chk("dec_funct", 64'(funct), 64'd0);
    drive(1, 32'h0800_0010, 32'h404, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("dec_j_type", 64'(j_type), 64'd1);
    drive(0, 0, 0, 1, 0);
    tick();

    // Flush with three held and a word on offer.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hD000_0000 + i, 32'h500 + 4 * i, 0, 0);
      tick();
    end
    drive(1, 32'hDEAD_BEEF, 32'h5FC, 0, 1);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready_after", 64'(in_ready), 64'd1);
    drive(1, 32'h0000_1111, 32'h600, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    #1;
    chk("fl_next_head", 64'(instr), 64'h0000_1111);
    tick();

    // Same-cycle hand-through versus one-cycle latency.
    drive(1, 32'h0043_0820, 32'h700, 1, 0);
    #1;
`ifdef IQ_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_instr", 64'(instr), 64'h0043_0820);
    chk("byp_rd", 64'(rd), 64'd1);
    tick();
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_out_valid0", 64'(out_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("nobyp_out_valid1", 64'(out_valid), 64'd1);
    chk("nobyp_instr", 64'(instr), 64'h0043_0820);
    chk("nobyp_rd", 64'(rd), 64'd1);
    drive(0, 0, 0, 1, 0);
    tick();
`endif

    // Randomised traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        d[31:26] = 6'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 7, d, $urandom,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      tick();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
